// File: rtl/multicycle_fetch_pkg.sv
// Shared types and constants for the multicycle MIPS fetch stage.
package multicycle_fetch_pkg;

  typedef enum logic {
    IDLE,
    REQ
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/multicycle_fetch_pc_unit.sv
// Architectural PC, pending branch/jump target and next-PC selection.
module pc_unit
  import multicycle_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_we,
  input  logic [31:0] pc_wdata,
  input  logic        in_req,
  input  logic        complete,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic        redirect_pending;
  logic [31:0] redirect_target;
  logic [31:0] pc_next;

  assign pc_plus4 = pc + 32'd4;

  // A same-cycle redirect beats a stored one, which beats sequential flow.
  always_comb begin
    pc_next = pc;
    if (!in_req && pc_we) begin
      pc_next = pc_wdata;
    end else if (complete) begin
      if (pc_we)                 pc_next = pc_wdata;
      else if (redirect_pending) pc_next = redirect_target;
      else                       pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= RESET_PC;
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0;
    end else begin
      pc <= pc_next;
      if (complete) begin
        redirect_pending <= 1'b0;
      end else if (in_req && pc_we) begin
        redirect_pending <= 1'b1;
        redirect_target  <= pc_wdata;
      end
    end
  end

endmodule

// File: rtl/multicycle_fetch.sv
// Fetch stage: one bus read per fetch_enable, latches IR and advances PC.
// Optional macro FETCH_ALIGN_CHECK_EN faults fetches from a misaligned PC.
module multicycle_fetch
  import multicycle_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_WORD = multicycle_fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        pc_we,
  input  logic [31:0] pc_wdata,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  fetch_state_t state;
  ibus_req_t    req_q;
  ibus_resp_t   resp;
  logic         in_req;
  logic         complete;

  assign resp       = '{data_ok: iresp_data_ok, data: iresp_data};
  assign ireq_valid = req_q.valid;
  assign ireq_addr  = req_q.addr;
  assign in_req     = (state == REQ);
  assign complete   = in_req && resp.data_ok;

  pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk      (clk),
    .reset    (reset),
    .pc_we    (pc_we),
    .pc_wdata (pc_wdata),
    .in_req   (in_req),
    .complete (complete),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err_q;
  logic misaligned;
  assign fetch_err  = fetch_err_q;
  assign misaligned = |pc[1:0];
`else
  assign fetch_err = 1'b0;
`endif

  // A redirect coinciding with fetch_enable defers launch by a cycle so the
  // request goes out on the new PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_q       <= '0;
      instruction <= NOP_WORD;
      fetch_busy  <= 1'b0;
      fetch_done  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      fetch_done <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fetch_enable && !pc_we) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
              instruction <= NOP_WORD;
              fetch_err_q <= 1'b1;
            end else
`endif
            begin
              state      <= REQ;
              req_q      <= '{valid: 1'b1, addr: {pc[31:2], 2'b00}};
              fetch_busy <= 1'b1;
            end
          end
        end
        REQ: begin
          if (resp.data_ok) begin
            instruction <= resp.data;
            req_q.valid <= 1'b0;
            fetch_busy  <= 1'b0;
            fetch_done  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_fetch.sv
// Self-checking bench for multicycle_fetch: directed cases plus random fetches
module tb_multicycle_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        pc_we = 1'b0;
  logic [31:0] pc_wdata = 32'h0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_err;

  int checks = 0;
  int passes = 0;

  // Reference model: architectural PC and IR as seen at transaction level
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  multicycle_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_enable  (fetch_enable),
    .pc_we         (pc_we),
    .pc_wdata      (pc_wdata),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .instruction   (instruction),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_busy    (fetch_busy),
    .fetch_done    (fetch_done),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic redirect_idle(input logic [31:0] tgt);
    pc_we = 1'b1;
    pc_wdata = tgt;
    tick();
    pc_we = 1'b0;
    m_pc = tgt;
    check32("idle_redirect_pc", pc, m_pc);
  endtask

  // One complete fetch. The last redirect seen during the request wins,
  // otherwise the PC advances by four (modulo 2^32).
  task automatic do_fetch(input int waits, input bit coincide, input logic [31:0] co_tgt,
                          input int redir_at, input logic [31:0] redir_tgt,
                          input int redir_pct, input logic [31:0] word);
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] last_tgt;
    bit          redir;
    fetch_enable = 1'b1;
    if (coincide) begin
      pc_we = 1'b1;
      pc_wdata = co_tgt;
      tick();
      pc_we = 1'b0;
      m_pc = co_tgt;
      check32("coincide_no_req", ireq_valid, 1'b0);
      check32("coincide_pc", pc, m_pc);
    end
    tick();
    fetch_enable = 1'b0;
    exp_addr = {m_pc[31:2], 2'b00};
    check32("launch_valid", ireq_valid, 1'b1);
    check32("launch_addr", ireq_addr, exp_addr);
    check32("launch_busy", fetch_busy, 1'b1);
    redir = 1'b0;
    last_tgt = 32'h0;
    for (int c = 0; c <= waits; c++) begin
      fetch_enable = 1'($urandom_range(0, 1));
      pc_we = ($urandom_range(0, 99) < redir_pct) || (c == redir_at);
      pc_wdata = (c == redir_at) ? redir_tgt : ($urandom & 32'hFFFF_FFFC);
      if (pc_we) begin
        redir = 1'b1;
        last_tgt = pc_wdata;
      end
      iresp_data_ok = (c == waits);
      iresp_data = (c == waits) ? word : $urandom;
      tick();
      pc_we = 1'b0;
      iresp_data_ok = 1'b0;
      fetch_enable = 1'b0;
      if (c < waits) begin
        check32("wait_valid", ireq_valid, 1'b1);
        check32("wait_addr", ireq_addr, exp_addr);
        check32("wait_busy", fetch_busy, 1'b1);
        check32("wait_no_done", fetch_done, 1'b0);
        check32("wait_pc", pc, m_pc);
      end
    end
    exp_pc = redir ? last_tgt : m_pc + 32'd4;
    m_pc = exp_pc;
    m_ir = word;
    check32("done_ir", instruction, m_ir);
    check32("done_pc", pc, m_pc);
    check32("done_pc_plus4", pc_plus4, m_pc + 32'd4);
    check32("done_pulse", fetch_done, 1'b1);
    check32("done_err", fetch_err, 1'b0);
    check32("done_busy", fetch_busy, 1'b0);
    check32("done_valid", ireq_valid, 1'b0);
    tick();
    check32("done_single_pulse", fetch_done, 1'b0);
    check32("idle_no_req", ireq_valid, 1'b0);
  endtask

  initial begin
    m_pc = RESET_PC;
    m_ir = NOP;
    $display("[TB] starting");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check32("rst_pc", pc, RESET_PC);
    check32("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    check32("rst_ir", instruction, NOP);
    check32("rst_valid", ireq_valid, 1'b0);
    check32("rst_addr", ireq_addr, 32'h0);
    check32("rst_busy", fetch_busy, 1'b0);
    check32("rst_done", fetch_done, 1'b0);
    check32("rst_err", fetch_err, 1'b0);

    // Zero-wait fetch from the reset vector
    do_fetch(0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h2008_0005);
    // Three wait cycles
    do_fetch(3, 1'b0, 32'h0, -1, 32'h0, 0, 32'h8C09_0004);
    // Redirect mid-request, then redirect on the completing cycle
    do_fetch(2, 1'b0, 32'h0, 1, 32'h0000_0100, 0, 32'h1234_5678);
    do_fetch(2, 1'b0, 32'h0, 2, 32'h0000_0200, 0, 32'hCAFE_0001);
    // Redirect coinciding with fetch_enable
    do_fetch(1, 1'b1, 32'h0000_4000, -1, 32'h0, 0, 32'h0BAD_F00D);

    // Stray response while idle must not touch IR
    iresp_data_ok = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 1'b0;
    check32("stray_ir", instruction, m_ir);
    check32("stray_done", fetch_done, 1'b0);
    check32("stray_pc", pc, m_pc);

    // PC wrap at the top of the address space
    redirect_idle(32'hFFFF_FFFC);
    do_fetch(1, 1'b0, 32'h0, -1, 32'h0, 0, 32'h0000_0021);
    check32("wrap_pc", pc, 32'h0000_0000);

    // Reset in the middle of a request, then a stale response
    fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    check32("pre_rst_valid", ireq_valid, 1'b1);
    reset = 1'b1;
    #1;
    check32("midrst_valid", ireq_valid, 1'b0);
    check32("midrst_pc", pc, RESET_PC);
    check32("midrst_ir", instruction, NOP);
    check32("midrst_busy", fetch_busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_pc = RESET_PC;
    m_ir = NOP;
    iresp_data_ok = 1'b1;
    iresp_data = 32'h1111_2222;
    tick();
    iresp_data_ok = 1'b0;
    check32("stale_ir", instruction, NOP);
    check32("stale_done", fetch_done, 1'b0);
    check32("stale_pc", pc, RESET_PC);

    // Random fetches with random wait states and redirects
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) redirect_idle($urandom & 32'hFFFF_FFFC);
      do_fetch($urandom_range(0, 4), 1'($urandom_range(0, 7) == 0),
               $urandom & 32'hFFFF_FFFC, -1, 32'h0, 15, $urandom);
    end

    // Misaligned PC handling
    redirect_idle(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    check32("align_no_req", ireq_valid, 1'b0);
    check32("align_err", fetch_err, 1'b1);
    check32("align_no_done", fetch_done, 1'b0);
    check32("align_ir", instruction, NOP);
    check32("align_pc", pc, 32'h0000_0102);
    tick();
    check32("align_err_pulse", fetch_err, 1'b0);
`else
    do_fetch(0, 1'b0, 32'h0, -1, 32'h0, 0, 32'h2402_000A);
    check32("misaligned_pc", pc, 32'h0000_0106);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_fetch.md
Name: multicycle_fetch

Overview:
- Fetch-stage unit of the multicycle MIPS core; sits directly upstream of the control FSM and feeds it the instruction word.
- On a fetch enable from the FSM it issues one instruction-bus read at the current PC, waits for the response, then latches the instruction register (IR) and advances the PC.
- Also owns the architectural PC and accepts redirects (branch/jump) from the datapath.
- Raises a busy flag so the FSM holds its fetch state while memory is slow.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, IR value on reset and on a faulted fetch.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_enable  in  1  FSM is in fetch state; sampled every cycle
- pc_we  in  1  datapath PC redirect strobe
- pc_wdata  in  32  redirect target
- ireq_valid  out  1  instruction-bus read request
- ireq_addr  out  32  request address, word aligned
- iresp_data_ok  in  1  response valid this cycle
- iresp_data  in  32  response word
- instruction  out  32  IR contents, consumed by FSM/decoder
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational
- fetch_busy  out  1  request outstanding; FSM must not leave fetch state
- fetch_done  out  1  one-cycle pulse: IR updated this cycle
- fetch_err  out  1  one-cycle fault pulse (see Optional Feature)

Behaviour:
- Reset values (async): state IDLE, pc=RESET_PC, instruction=NOP_WORD, ireq_valid=0, ireq_addr=0, fetch_busy=0, fetch_done=0, fetch_err=0, redirect_pending=0.
- States: IDLE, REQ.
- IDLE:
  - fetch_enable=1 -> REQ; next cycle ireq_valid=1, ireq_addr={pc[31:2],2'b00}, fetch_busy=1.
  - pc_we=1 in IDLE -> pc<=pc_wdata next cycle. If it coincides with fetch_enable, the request uses the new PC: PC write first, request launched one cycle later.
- REQ:
  - ireq_valid and ireq_addr held stable until iresp_data_ok.
  - On iresp_data_ok: instruction<=iresp_data; pc<=redirect target if pending, else pc+4; ireq_valid<=0; fetch_busy<=0; fetch_done<=1 for one cycle; -> IDLE.
  - fetch_enable while in REQ is ignored; no second request.
  - iresp_data_ok while in IDLE is ignored; IR unchanged.
- Redirect during REQ:
  - pc_we stores pc_wdata in a pending register; it does not disturb ireq_addr.
  - On completion the pending target replaces pc+4, then pending clears.
  - pc_we in the same cycle as iresp_data_ok: pc_wdata wins over pc+4.
  - Multiple pc_we during one REQ: the last one wins.
- Latency with a zero-wait bus:
  - fetch_enable at cycle T.
  - ireq_valid at T+1; data_ok at T+1.
  - instruction/pc updated and fetch_done high at T+2.
  - Each extra wait cycle adds one.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Reset mid-REQ: ireq_valid drops immediately; the in-flight response is ignored after reset deasserts.
- fetch_done and fetch_err are never high together.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - fetch_enable in IDLE with pc[1:0]!=0 issues no request.
  - Next cycle: instruction<=NOP_WORD, fetch_err=1 for one cycle, pc unchanged, state stays IDLE.
  - Misaligned pc_wdata is accepted; the fault is raised at the next fetch.
- Not defined: ireq_addr forces bits [1:0] to 0, and fetch_err is tied 0.

Decomposition:
- Shared package (pipes): typedef fetch_state_t (IDLE, REQ); ibus_req_t {valid, addr}; ibus_resp_t {data_ok, data}; constants PC_RESET_DEFAULT and NOP_WORD.
- One sub-module, pc_unit: PC register, pending-redirect register, next-PC mux (pc_wdata / pending / pc+4), pc_plus4 adder. The FSM and IR stay in the top.

Test Plan:
- Reset then fetch_enable, zero-wait memory returning 32'h2008_0005 -> ireq_addr=32'hBFC0_0000 at T+1; instruction=32'h2008_0005, pc=32'hBFC0_0004, fetch_done pulse at T+2.
- Memory with 3 wait cycles -> ireq_valid and ireq_addr stable for 4 cycles; fetch_busy high throughout; a single fetch_done pulse.
- pc_we=1 with pc_wdata=32'h0000_0100 mid-REQ -> request address unchanged; after completion pc=32'h0000_0100, not old pc+4.
- pc=32'hFFFF_FFFC fetch completes -> pc wraps to 32'h0000_0000.
- Reset asserted while in REQ, then a stale data_ok after release -> ireq_valid=0 at once; pc=RESET_PC; instruction=NOP_WORD; no fetch_done.
- FETCH_ALIGN_CHECK_EN defined, pc_wdata=32'h0000_0102 then fetch_enable -> no ireq_valid; fetch_err pulse; instruction=NOP_WORD; pc stays 32'h0000_0102.
